// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encodings, default word width, SCLK mode constants.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_t;

  localparam int SPI_DATA_W_DEF = 8;

  localparam logic SPI_CPOL_IDLE_LO = 1'b0;
  localparam logic SPI_CPOL_IDLE_HI = 1'b1;
  localparam logic SPI_CPHA_LEAD    = 1'b0;
  localparam logic SPI_CPHA_TRAIL   = 1'b1;

endpackage

// File: rtl/spi_tick_gen.sv
// Turns the upstream divided clock into single-cycle ticks in the i_clk_sys domain.
// Each tick marks one SCLK half-period.
module spi_tick_gen (
  input  logic i_clk_sys,
  input  logic i_rst,
  input  logic i_clk_div,
  output logic o_tick
);

  // [0],[1] form the synchroniser, [2] is the previous synchronised level
  logic [2:0] sync;

  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) sync <= '0;
    else       sync <= {sync[1:0], i_clk_div};
  end

  assign o_tick = sync[1] & ~sync[2];

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine, one word per transfer, paced by ticks from spi_tick_gen.
// Build option: define SPI_LSB_FIRST_EN to shift LSB-first on MOSI and MISO.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int   DATA_W = SPI_DATA_W_DEF,
  parameter logic CPOL   = SPI_CPOL_IDLE_LO,
  parameter logic CPHA   = SPI_CPHA_LEAD
) (
  input  logic              i_clk_sys,
  input  logic              i_rst,
  input  logic              i_clk_div,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_busy,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic              o_cs_n,
  input  logic              i_miso
);

  localparam int            HW        = $clog2(2 * DATA_W);
  localparam logic [HW-1:0] HALF_LAST = HW'(2 * DATA_W - 1);

  function automatic logic out_bit(input logic [DATA_W-1:0] w);
`ifdef SPI_LSB_FIRST_EN
    return w[0];
`else
    return w[DATA_W-1];
`endif
  endfunction

  function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] w);
`ifdef SPI_LSB_FIRST_EN
    return w >> 1;
`else
    return w << 1;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] push_bit(input logic [DATA_W-1:0] w, input logic b);
`ifdef SPI_LSB_FIRST_EN
    return {b, w[DATA_W-1:1]};
`else
    return {w[DATA_W-2:0], b};
`endif
  endfunction

  logic              tick;
  spi_state_t        state;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [HW-1:0]     half_cnt;
  logic              sample_edge;

  spi_tick_gen u_tick (
    .i_clk_sys (i_clk_sys),
    .i_rst     (i_rst),
    .i_clk_div (i_clk_div),
    .o_tick    (tick)
  );

  // Even half counts are leading edges; CPHA picks which parity samples MISO
  assign sample_edge = (half_cnt[0] == (CPHA == SPI_CPHA_TRAIL));

  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      tx_sh      <= '0;
      rx_sh      <= '0;
      half_cnt   <= '0;
      o_tx_ready <= 1'b0;
      o_busy     <= 1'b0;
      o_cs_n     <= 1'b1;
      o_sclk     <= CPOL;
      o_mosi     <= 1'b0;
      o_rx_valid <= 1'b0;
      o_rx_data  <= '0;
    end else begin
      o_rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (o_tx_ready && i_tx_valid) begin
            o_tx_ready <= 1'b0;
            o_busy     <= 1'b1;
            o_cs_n     <= 1'b0;
            half_cnt   <= '0;
            rx_sh      <= '0;
            // CPHA=0 must present the first bit before the first leading edge
            if (CPHA == SPI_CPHA_LEAD) begin
              o_mosi <= out_bit(i_tx_data);
              tx_sh  <= drop_bit(i_tx_data);
            end else begin
              tx_sh  <= i_tx_data;
            end
            state <= ST_SETUP;
          end else begin
            o_tx_ready <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (tick) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (tick) begin
            o_sclk <= ~o_sclk;
            if (sample_edge) begin
              rx_sh <= push_bit(rx_sh, i_miso);
            end else begin
              o_mosi <= out_bit(tx_sh);
              tx_sh  <= drop_bit(tx_sh);
            end
            if (half_cnt == HALF_LAST) state    <= ST_HOLD;
            else                       half_cnt <= half_cnt + HW'(1);
          end
        end
        ST_HOLD: begin
          if (tick) begin
            o_sclk     <= CPOL;
            o_cs_n     <= 1'b1;
            o_rx_data  <= rx_sh;
            o_rx_valid <= 1'b1;
            state      <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tick) begin
            o_busy     <= 1'b0;
            o_tx_ready <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 Parameter DATA_W, default 8: bits per transfer, minimum 2.
REQ-002 Parameter CPOL, default 0: idle SCLK level.
REQ-003 Parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 i_clk_sys  in  1  sole clock; one clock, all state on its rising edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_clk_div  in  1  divided-clock output of the upstream divider, sampled as data (never used as a clock).
REQ-007 i_tx_valid  in  1  / o_tx_ready  out  1  transmit handshake; transfer occurs when both are high on a clock edge.
REQ-008 i_tx_data  in  DATA_W  word to send, captured at the handshake.
REQ-009 o_rx_data  out  DATA_W  / o_rx_valid  out  1  received word, plus a 1-cycle qualifying pulse.
REQ-010 o_busy  out  1  high from the handshake until return to IDLE.
REQ-011 o_sclk, o_mosi, o_cs_n  out  1 each; i_miso  in  1  SPI pins.

Function
REQ-012 Tick generation: two-flop synchronise i_clk_div, then flag a tick for one cycle on each rising edge of the synchronised copy; one tick is one SCLK half-period.
REQ-013 The engine advances only on ticks. If i_clk_div stops toggling, the engine stalls in its current state with all outputs held.
REQ-014 FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
REQ-015 IDLE: o_tx_ready=1. On handshake: load shift register, assert o_cs_n=0 the next cycle, go to SETUP.
REQ-016 SETUP: lasts 1 tick.
- CPHA=0: the first data bit is already on o_mosi.
- On exit, go to SHIFT.
REQ-017 SHIFT: toggle o_sclk each tick for exactly 2*DATA_W ticks using a half-bit counter.
- Sample i_miso on the sample edge.
- Update o_mosi on the opposite edge; for CPHA=1 this includes the first leading edge.
REQ-018 HOLD: 1 tick.
- o_sclk stays at CPOL.
- At the tick, o_cs_n goes to 1, o_rx_data is updated and o_rx_valid pulses for exactly 1 cycle.
- Go to GAP.
REQ-019 GAP: 1 tick with o_cs_n=1, then go to IDLE.
- The earliest next handshake is the cycle after entering IDLE.
- Guarantees a CS-high time of at least 1 tick.
REQ-020 o_tx_ready=0 in every state except IDLE. i_tx_valid outside IDLE is ignored and i_tx_data is not sampled.
REQ-021 Total transfer time from the handshake: 2*DATA_W+3 ticks, plus up to 1 tick of alignment.
REQ-022 o_rx_data holds its value until the next HOLD. The bit counter never wraps; it saturates at the exit condition.

Reset
REQ-023 i_rst asserted forces, immediately and in any state (including mid-SHIFT):
- IDLE state
- o_cs_n=1, o_sclk=CPOL, o_mosi=0
- o_rx_valid=0, o_rx_data=0, o_busy=0, o_tx_ready=0
- tick synchronisers=0
REQ-024 o_tx_ready rises on the first clock edge after i_rst deasserts. A partially shifted word is discarded, with no o_rx_valid.

Configuration
REQ-025 Macro SPI_LSB_FIRST_EN:
- Defined: shift LSB-first on both MOSI and MISO.
- Undefined: shift MSB-first (default).

Structure
REQ-026 Shared package/include spi_pkg holds the FSM state encodings, the default DATA_W and the CPOL/CPHA mode constants.
REQ-027 Sub-module spi_tick_gen holds the synchroniser and rising-edge detector, with output o_tick.

Verification
REQ-028 Configuration: CPOL=0, CPHA=0, i_clk_div period of 16 cycles, i_miso looped to o_mosi. Send 0xA5 -> o_rx_data=0xA5 with one o_rx_valid pulse; exactly 8 SCLK rising edges; o_cs_n low for 18 ticks.
REQ-029 Send 0x3C with i_miso=1 -> MOSI bits 0,0,1,1,1,1,0,0 at the sample edges; o_rx_data=0xFF. Repeat with CPHA=1, CPOL=1 -> same data with shifted edges.
REQ-030 Hold i_tx_valid high with 0x11, then 0x22 -> 0x22 is accepted only after GAP; two o_rx_valid pulses; o_cs_n high for at least 1 tick between the transfers.
REQ-031 Assert i_rst after 3 bits of 0xF0 -> outputs take reset values the same cycle; no o_rx_valid. After release, send 0x5A -> received 0x5A.
REQ-032 Hold i_clk_div constant mid-SHIFT for 100 cycles -> no SCLK edges, o_cs_n stays 0, no o_rx_valid; resume -> completes correctly.
REQ-033 SPI_LSB_FIRST_EN defined, send 0x01 -> first MOSI bit is 1, remaining bits 0; loopback o_rx_data=0x01.
